vga_cell_prefetch: RTL and testbench
====================================

Name: vga_cell_prefetch

Overview:
- Sits between the dmem VGA read port and the vga timing/colour stage, in the VGA_CLK domain.
- During horizontal blanking it fetches one row of Game-of-Life cell bytes from dmem into a ping-pong line buffer.
- During active video it serves the cell byte under the current pixel, so the vga stage never issues memory reads directly.
- Removes the combinational pixel-to-address-to-data path and absorbs dmem read latency.

Parameters:
- H_CELLS, 80, cells per row (640/8)
- V_CELLS, 60, cell rows per frame (480/8)
- CELL_SHIFT, 3, log2 of cell size in pixels (8x8)
- BASE_ADDR, 32'h0000_0000, byte address of cell (0,0) in dmem
- WORD_STRIDE, 4, byte distance between consecutive cells (one 32-bit word per cell)

Ports:
- sysclk  in  1  pixel clock (driven from VGA_CLK)
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse at start of horizontal blanking
- line_y  in  10  scan line that follows the blanking in which line_start pulses
- pix_x  in  10  current pixel column
- pix_valid  in  1  pixel is in display area
- mem_addr  out  32  dmem read address
- mem_rdata  in  8  dmem read data, low byte; valid 1 cycle after mem_addr
- cell_state  out  8  cell byte for current pixel
- cell_valid  out  1  cell_state is meaningful
- underrun  out  1  sticky: a fetch failed to finish before the next line_start

Behaviour:
- Reset values: mem_addr=0, cell_state=0, cell_valid=0, underrun=0, FSM=IDLE, front bank=0. Buffer contents are not cleared.
- Fetch trigger: on line_start, if line_y[CELL_SHIFT-1:0]==0 and (line_y>>CELL_SHIFT) < V_CELLS, then row r = line_y>>CELL_SHIFT and the FSM enters FETCH. Otherwise stay IDLE.
- FSM states:
  - IDLE -> FETCH on trigger.
  - FETCH: col runs 0..H_CELLS-1. mem_addr = BASE_ADDR + (r*H_CELLS + col)*WORD_STRIDE, computed in 32 bits with no wrap handling. Goes to DRAIN after col = H_CELLS-1.
  - DRAIN: one cycle to capture the last byte, then -> SWAP.
  - SWAP: toggle front bank, set cell_valid_row=1, then -> IDLE.
- Capture: mem_rdata sampled the cycle after each address issue and written to back_bank[col_d1].
- Total fetch length: H_CELLS+2 cycles (82), which fits the 160-cycle 640x480 hblank.
- Outside FETCH, mem_addr holds its last value.
- Pixel path, 1-cycle latency from pix_x/pix_valid:
  - cell_state <= front_bank[pix_x>>CELL_SHIFT] when pix_valid and pix_x>>CELL_SHIFT < H_CELLS; otherwise 0.
  - cell_valid <= pix_valid & cell_valid_row.
- Rows sharing a cell row (line_y[2:0]≠0) reuse the front bank; no fetch.
- Underrun: line_start arriving while in FETCH or DRAIN sets underrun. The FSM aborts, swaps banks anyway (partial row displayed), then evaluates the new trigger in the same cycle. underrun clears only on reset.
- line_start coinciding with SWAP: SWAP completes first, and the trigger is honoured in the same cycle (SWAP -> FETCH).
- Reset mid-fetch: FSM returns to IDLE immediately and cell_valid_row=0 until the next complete fetch.
- Frame wrap: the prefetch of row 0 happens on line_start with line_y=0, issued by the timing stage in the last vblank line.

Optional Feature:
- Macro VGA_CELL_GRID_EN.
- Defined: pixels with pix_x[CELL_SHIFT-1:0]==0, or the current line's low bits ==0, output GRID_COLOR (8'h49) instead of the cell byte when cell_valid is 1. The line's low bits are latched from line_y at line_start.
- Undefined: no grid and no latched line register; cell_state is pure buffer data.

Decomposition:
- Package vga_fetch_pkg holds:
  - fetch_state_t enum (IDLE, FETCH, DRAIN, SWAP)
  - GRID_COLOR
  - default H_CELLS/V_CELLS/CELL_SHIFT constants
- Sub-module line_buffer_2bank:
  - two banks of H_CELLS x 8 bits
  - one write port (bank, index, data, we)
  - one registered read port (bank, index)
  - this is the natural split; the FSM and address arithmetic stay in the top block.

Test Plan:
- Reset, then line_start with line_y=0, dmem model returning byte=col. Expect mem_addr to step 0x0,0x4,...,0x13C, swap after 82 cycles, and a pixel sweep to give cell_state = pix_x>>3, one cycle after pix_x.
- line_start with line_y=8. Expect first mem_addr=0x140 (row 1) and last mem_addr=0x27C. line_y=9..15 cause no fetch.
- line_start with line_y=480. Expect no fetch and mem_addr unchanged.
- Second line_start 50 cycles into a fetch. Expect underrun=1 and persisting, with front bank showing cols 0..48 new and the rest stale.
- Assert reset at col=40 of a fetch. Next cycle expect FSM IDLE, cell_valid=0, underrun=0; a subsequent full fetch restores cell_valid=1 in active video.
- With VGA_CELL_GRID_EN: pix_x=16 on line_y=3 gives 8'h49; pix_x=17 gives the cell byte. Without the macro, pix_x=16 gives the cell byte.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg: shared types and defaults for the VGA cell prefetcher
package vga_fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} fetch_state_t;
  localparam logic [7:0] GRID_COLOR = 8'h49;
  localparam int DEF_H_CELLS = 80;
  localparam int DEF_V_CELLS = 60;
  localparam int DEF_CELL_SHIFT = 3;
endpackage

// File: rtl/line_buffer_2bank.sv
// line_buffer_2bank: two H_CELLS x 8 banks, one write port, one registered read port
module line_buffer_2bank
  import vga_fetch_pkg::*;
#(
  parameter int H_CELLS = DEF_H_CELLS,
  localparam int IW = $clog2(H_CELLS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic          rd_bank,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [2][H_CELLS];
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_idx] <= wr_data;
    rd_data <= mem[rd_bank][rd_idx];
  end
endmodule

// File: rtl/vga_cell_prefetch.sv
// vga_cell_prefetch: fetches one cell row per hblank into a ping-pong buffer and serves it per pixel.
// Define VGA_CELL_GRID_EN to overlay an 8x8 cell grid in GRID_COLOR.
module vga_cell_prefetch
  import vga_fetch_pkg::*;
#(
  parameter int          H_CELLS     = DEF_H_CELLS,
  parameter int          V_CELLS     = DEF_V_CELLS,
  parameter int          CELL_SHIFT  = DEF_CELL_SHIFT,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WORD_STRIDE = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  pix_x,
  input  logic        pix_valid,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  cell_state,
  output logic        cell_valid,
  output logic        underrun
);
  localparam int IW = $clog2(H_CELLS);
  fetch_state_t state;
  logic [IW-1:0] col, col_d1, rd_idx;
  logic front, valid_row, cap_we, pix_ok_d, trig, busy, swap;
  logic [7:0] rd_data;
  logic [31:0] row_base;
  assign trig = line_start && line_y[CELL_SHIFT-1:0] == '0 && 32'(line_y >> CELL_SHIFT) < 32'(V_CELLS);
  assign busy = state == FETCH || state == DRAIN;
  assign swap = state == SWAP || (busy && line_start);
  assign row_base = BASE_ADDR + 32'(line_y >> CELL_SHIFT) * 32'(H_CELLS * WORD_STRIDE);
  assign rd_idx = IW'(pix_x >> CELL_SHIFT);
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      col_d1     <= '0;
      cap_we     <= 1'b0;
      front      <= 1'b0;
      valid_row  <= 1'b0;
      underrun   <= 1'b0;
      mem_addr   <= '0;
      cell_valid <= 1'b0;
      pix_ok_d   <= 1'b0;
    end else begin
      col_d1     <= col;
      // an aborting line_start must not let the in-flight byte land in the new back bank
      cap_we     <= state == FETCH && !line_start;
      cell_valid <= pix_valid && valid_row;
      pix_ok_d   <= pix_valid && 32'(pix_x >> CELL_SHIFT) < 32'(H_CELLS);
      if (swap) begin
        front     <= ~front;
        valid_row <= 1'b1;
      end
      if (busy && line_start) underrun <= 1'b1;
      if (trig) begin
        state    <= FETCH;
        col      <= '0;
        mem_addr <= row_base;
      end else if (line_start || state == SWAP) state <= IDLE;
      else if (state == DRAIN) state <= SWAP;
      else if (state == FETCH) begin
        if (col == IW'(H_CELLS - 1)) state <= DRAIN;
        else begin
          col      <= col + 1'b1;
          mem_addr <= mem_addr + 32'(WORD_STRIDE);
        end
      end
    end
  end
  line_buffer_2bank #(.H_CELLS(H_CELLS)) u_buf (
    .clk    (sysclk),
    .we     (cap_we),
    .wr_bank(~front),
    .wr_idx (col_d1),
    .wr_data(mem_rdata),
    .rd_bank(front),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );
`ifdef VGA_CELL_GRID_EN
  logic [CELL_SHIFT-1:0] line_lo;
  logic gx_d;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      line_lo <= '0;
      gx_d    <= 1'b0;
    end else begin
      if (line_start) line_lo <= line_y[CELL_SHIFT-1:0];
      gx_d <= pix_x[CELL_SHIFT-1:0] == '0;
    end
  end
  assign cell_state = !pix_ok_d ? 8'h00 : (cell_valid && (gx_d || line_lo == '0)) ? GRID_COLOR : rd_data;
`else
  assign cell_state = pix_ok_d ? rd_data : 8'h00;
`endif
endmodule

// File: tb/tb_vga_cell_prefetch.sv
// tb_vga_cell_prefetch: directed bench with a row-level ping-pong model checked every cycle
module tb_vga_cell_prefetch;
`ifdef VGA_CELL_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif
  logic clk, rst, ls, pv;
  logic [9:0] ly, px;
  logic [31:0] mem_addr;
  logic [7:0] mem_rdata, cell_state;
  logic cell_valid, underrun;
  int total, bad;
  bit chk_on;
  // model state: two row images, which one is on screen, and fetch progress in cycles
  int bk[2][80];
  int f, n, row, line_lo, exp_cs, exp_cv, exp_ur, idx, v;
  logic [31:0] exp_addr;
  bit active, vrow, trig_m, ab;

  vga_cell_prefetch dut (
    .sysclk    (clk),
    .reset     (rst),
    .line_start(ls),
    .line_y    (ly),
    .pix_x     (px),
    .pix_valid (pv),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .cell_state(cell_state),
    .cell_valid(cell_valid),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem: one word per cell, low byte = word index
  always @(posedge clk) mem_rdata <= mem_addr[9:2];

  initial begin
    for (int b = 0; b < 2; b++) for (int c = 0; c < 80; c++) bk[b][c] = -1;
    active = 0; vrow = 0; f = 0; n = 0; row = 0; line_lo = 0;
    exp_cs = 0; exp_cv = 0; exp_ur = 0; exp_addr = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (active) for (int c = 0; c < 80; c++) bk[1-f][c] = -1;
      active = 0; vrow = 0; f = 0; exp_ur = 0; exp_addr = 0;
      exp_cs = 0; exp_cv = 0; line_lo = 0;
    end else begin
      if (ls) line_lo = int'(ly) % 8;
      idx = int'(px) / 8;
      exp_cv = (pv && vrow) ? 1 : 0;
      v = (pv && idx < 80) ? bk[f][idx] : 0;
      if (GRID && pv && idx < 80 && exp_cv == 1 && (int'(px) % 8 == 0 || line_lo == 0)) v = 'h49;
      exp_cs = v;
      trig_m = ls && int'(ly) % 8 == 0 && int'(ly) / 8 < 60;
      if (active) begin
        n++;
        if (n >= 2 && n <= 81) bk[1-f][n-2] = (row * 80 + n - 2) % 256;
        ab = ls && n <= 81;
        if (ab) exp_ur = 1;
        else if (n <= 79) exp_addr = 32'(row * 320 + n * 4);
        if (ab || n == 82) begin
          f = 1 - f; vrow = 1; active = 0;
        end
      end
      if (trig_m) begin
        active = 1; n = 0; row = int'(ly) / 8; exp_addr = 32'(row * 320);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("cell_valid", 32'(cell_valid), 32'(exp_cv));
    chk("underrun", 32'(underrun), 32'(exp_ur));
    chk("mem_addr", mem_addr, exp_addr);
    if (exp_cs >= 0) chk("cell_state", 32'(cell_state), 32'(exp_cs));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int y);
    ls = 1'b1; ly = 10'(y);
    step();
    ls = 1'b0;
  endtask

  task automatic pix(input int x);
    pv = 1'b1; px = 10'(x);
    step();
  endtask

  task automatic sweep();
    for (int x = 0; x < 656; x++) pix(x);
    pv = 1'b0;
    step();
  endtask

  initial begin
    total = 0; bad = 0; chk_on = 0;
    rst = 1'b1; ls = 1'b0; ly = '0; px = '0; pv = 1'b0;
    repeat (2) step();
    chk_on = 1;
    step();
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ur", 32'(underrun), 32'h0);
    chk("rst_cv", 32'(cell_valid), 32'h0);
    chk("rst_cs", 32'(cell_state), 32'h0);
    rst = 1'b0;
    // row 0
    line(0);
    chk("r0_first", mem_addr, 32'h0);
    repeat (79) step();
    chk("r0_last", mem_addr, 32'h13c);
    repeat (3) step();
    line(1);
    pix(100);
    chk("r0_pix100", 32'(cell_state), 32'd12);
    chk("r0_cv", 32'(cell_valid), 32'h1);
    sweep();
    // row 1, then lines that share it
    line(8);
    chk("r1_first", mem_addr, 32'h140);
    repeat (79) step();
    chk("r1_last", mem_addr, 32'h27c);
    repeat (3) step();
    for (int y = 9; y < 16; y++) begin
      line(y);
      step();
    end
    chk("r1_nofetch", mem_addr, 32'h27c);
    pix(9);
    chk("r1_pix9", 32'(cell_state), 32'd81);
    sweep();
    line(480);
    repeat (5) step();
    chk("y480_addr", mem_addr, 32'h27c);
    // line_start landing on the swap cycle starts the next fetch straight away
    line(24);
    repeat (81) step();
    line(32);
    chk("swap_fetch_addr", mem_addr, 32'h500);
    chk("swap_no_ur", 32'(underrun), 32'h0);
    sweep();
    // underrun: abort row 2 after 50 cycles
    line(16);
    repeat (49) step();
    line(1);
    chk("ur_set", 32'(underrun), 32'h1);
    pix(385);
    chk("ur_new_col48", 32'(cell_state), 32'd208);
    pix(393);
    chk("ur_stale_col49", 32'(cell_state), 32'd33);
    pv = 1'b0;
    repeat (10) step();
    chk("ur_sticky", 32'(underrun), 32'h1);
    // reset in the middle of a fetch
    line(40);
    repeat (41) step();
    pv = 1'b1; px = 10'd1; rst = 1'b1;
    step();
    chk("mr_cv", 32'(cell_valid), 32'h0);
    chk("mr_ur", 32'(underrun), 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    rst = 1'b0;
    repeat (5) step();
    chk("mr_cv_hold", 32'(cell_valid), 32'h0);
    pv = 1'b0;
    line(40);
    repeat (82) step();
    line(1);
    pix(1);
    chk("mr_restore_cv", 32'(cell_valid), 32'h1);
    chk("mr_pix1", 32'(cell_state), 32'd144);
    // grid column on a non-boundary line
    line(3);
    pix(16);
`ifdef VGA_CELL_GRID_EN
    chk("grid_pix16", 32'(cell_state), 32'h49);
`else
    chk("nogrid_pix16", 32'(cell_state), 32'd146);
`endif
    pix(17);
    chk("pix17", 32'(cell_state), 32'd146);
    pv = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
